hssi_lpbk_tester: RTL and testbench

HSSI_LPBK_TESTER -- requirements
Module: hssi_lpbk_tester

---
 rtl/hssi_tester_pkg.sv | 35 +++
 rtl/hssi_lane_checker.sv | 35 +++
 rtl/hssi_lpbk_tester.sv | 193 +++++++++++++++++++
 tb/tb_hssi_lpbk_tester.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hssi_tester_pkg.sv
// Shared definitions for the HSSI loopback tester.
// Holds the FSM state encoding, lane control-word layout constants and the
// function that builds the expected word for a given lane and sequence number.
package hssi_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_LOCK,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam int CTL_VLD_BIT = 17;  // per-lane "word valid" flag in control
  localparam int TX_CTL_W    = 18;
  localparam int RX_CTL_W    = 20;
  localparam int LOCK_CYC    = 8;   // consecutive rx_ready cycles needed
  localparam int MAX_LANE_DW = 256; // widest lane the word function supports

  localparam logic [TX_CTL_W-1:0] TX_CTL_VALID = TX_CTL_W'(1) << CTL_VLD_BIT;

  // Lane word layout: lane number in the top byte, sequence number
  // zero-extended or truncated into the remaining dw-8 bits. The result is
  // returned zero-extended to MAX_LANE_DW bits.
  function automatic logic [MAX_LANE_DW-1:0] lane_word(input int unsigned dw,
                                                       input logic [7:0]  lane,
                                                       input logic [31:0] seq);
    logic [MAX_LANE_DW-1:0] seq_ext;
    logic [MAX_LANE_DW-1:0] mask;
    seq_ext = MAX_LANE_DW'(seq);
    mask    = {MAX_LANE_DW{1'b1}} >> (MAX_LANE_DW - (dw - 8));
    return (MAX_LANE_DW'(lane) << (dw - 8)) | (seq_ext & mask);
  endfunction

endpackage

// File: rtl/hssi_lane_checker.sv
// Per-lane receive checker: compares one lane word with its expected value.
// Ports: clk/rst, check_en (valid rx cycle), rx_seq (expected sequence),
// rx_lane (received word) -> mismatch_o, registered one cycle later.
module hssi_lane_checker
  import hssi_tester_pkg::*;
#(
  parameter int LANE_DW  = 64,
  parameter int LANE_IDX = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               check_en,
  input  logic [31:0]        rx_seq,
  input  logic [LANE_DW-1:0] rx_lane,
  output logic               mismatch_o
);

  logic mismatch_d;
  logic mismatch_q;

  // Compare at full function width; the upper bits of the expected word are
  // always zero, so this is equivalent to a LANE_DW-bit compare.
  always_comb begin
    mismatch_d = check_en &&
                 (MAX_LANE_DW'(rx_lane) != lane_word(LANE_DW, 8'(LANE_IDX), rx_seq));
  end

  always_ff @(posedge clk) begin
    if (rst) mismatch_q <= 1'b0;
    else     mismatch_q <= mismatch_d;
  end

  assign mismatch_o = mismatch_q;

endmodule

// File: rtl/hssi_lpbk_tester.sv
// HSSI loopback tester: sends a numbered word stream on every lane and checks
// what comes back. Ports: pClk/pck_cp2af_softReset, start/num_words/rx_ready
// control, tx_data/tx_control out, rx_data/rx_control in, status outputs.
module hssi_lpbk_tester
  import hssi_tester_pkg::*;
#(
  parameter int NUM_LANES   = 4,
  parameter int LANE_DW     = 64,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                           pClk,
  input  logic                           pck_cp2af_softReset,
  input  logic                           start,
  input  logic [31:0]                    num_words,
  input  logic                           rx_ready,
  output logic [NUM_LANES*LANE_DW-1:0]   tx_data,
  output logic [NUM_LANES*TX_CTL_W-1:0]  tx_control,
  input  logic [NUM_LANES*LANE_DW-1:0]   rx_data,
  input  logic [NUM_LANES*RX_CTL_W-1:0]  rx_control,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic [15:0]                    err_count,
  output logic [31:0]                    rx_words,
  output logic                           timeout
);

  localparam int LOCK_W = $clog2(LOCK_CYC);
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

  state_e              state_q, state_d;
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [31:0]         num_words_q, num_words_d;
  logic [31:0]         tx_sent_q, tx_sent_d;
  logic [31:0]         tx_seq_q, tx_seq_d;
  logic [31:0]         rx_seq_q, rx_seq_d;
  logic [31:0]         rx_words_q, rx_words_d;
  logic [15:0]         err_count_q, err_count_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic                timeout_q, timeout_d;
  logic                valid_q, valid_d;     // check pipeline holds a valid word
  logic                partial_q, partial_d; // check pipeline holds a partial cycle

  logic [NUM_LANES-1:0] rx_vld_lanes;
  logic [NUM_LANES-1:0] mis;
  logic                 rx_all, rx_any, checking, check_en, sending;
  logic [16:0]          err_add;
  logic [17:0]          err_sum;

  // Only the valid bit of each rx control lane is acted upon.
  logic unused_rx_ctl;
  assign unused_rx_ctl = ^rx_control;

  assign rx_all   = &rx_vld_lanes;
  assign rx_any   = |rx_vld_lanes;
  assign checking = (state_q == ST_WAIT_LOCK) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign check_en = checking && rx_all;
  assign sending  = (state_q == ST_RUN) && (tx_sent_q < num_words_q);

  for (genvar p = 0; p < NUM_LANES; p++) begin : g_lane
    assign rx_vld_lanes[p] = rx_control[p*RX_CTL_W + CTL_VLD_BIT];
    // Same layout as lane_word(), sized directly to the lane.
    assign tx_data[p*LANE_DW +: LANE_DW]     = sending ? {8'(p), (LANE_DW-8)'(tx_seq_q)} : '0;
    assign tx_control[p*TX_CTL_W +: TX_CTL_W] = sending ? TX_CTL_VALID : '0;

    hssi_lane_checker #(.LANE_DW(LANE_DW), .LANE_IDX(p)) u_chk (
      .clk        (pClk),
      .rst        (pck_cp2af_softReset),
      .check_en   (check_en),
      .rx_seq     (rx_seq_q),
      .rx_lane    (rx_data[p*LANE_DW +: LANE_DW]),
      .mismatch_o (mis[p])
    );
  end

  always_comb begin
    state_d     = state_q;
    lock_cnt_d  = lock_cnt_q;
    num_words_d = num_words_q;
    tx_sent_d   = tx_sent_q;
    tx_seq_d    = tx_seq_q;
    rx_seq_d    = rx_seq_q;
    rx_words_d  = rx_words_q;
    idle_cnt_d  = idle_cnt_q;
    timeout_d   = timeout_q;
    valid_d     = check_en;
    partial_d   = checking && rx_any && !rx_all;

    // Retire last cycle's check result; a partial cycle costs every lane.
    err_add = '0;
    if (partial_q) begin
      err_add = 17'(NUM_LANES);
    end else begin
      for (int p = 0; p < NUM_LANES; p++) err_add = err_add + 17'(mis[p]);
    end
    err_sum     = 18'(err_count_q) + 18'(err_add);
    err_count_d = (err_sum > 18'h0FFFF) ? 16'hFFFF : err_sum[15:0];

    if (check_en) begin
      rx_seq_d   = rx_seq_q + 32'd1;
      rx_words_d = rx_words_q + 32'd1;
    end
    if (sending) begin
      tx_seq_d  = tx_seq_q + 32'd1;
      tx_sent_d = tx_sent_q + 32'd1;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_WAIT_LOCK;
          num_words_d = num_words;
          lock_cnt_d  = '0;
          tx_sent_d   = '0;
          tx_seq_d    = '0;
          rx_seq_d    = '0;
          rx_words_d  = '0;
          err_count_d = '0;
          idle_cnt_d  = '0;
          timeout_d   = 1'b0;
        end
      end
      ST_WAIT_LOCK: begin
        if (!rx_ready) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LOCK_W'(LOCK_CYC - 1)) begin
          state_d    = (num_words_q == 32'd0) ? ST_DRAIN : ST_RUN;
          idle_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end
      end
      ST_RUN: begin
        if (!sending) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((rx_words_q == num_words_q) && !valid_q && !partial_q) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Idle watchdog; overrides the normal RUN/DRAIN transitions.
    if ((state_q == ST_RUN) || (state_q == ST_DRAIN)) begin
      if (rx_all) begin
        idle_cnt_d = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        if (idle_cnt_d == IDLE_W'(TIMEOUT_CYC)) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
    end
  end

  always_ff @(posedge pClk) begin
    if (pck_cp2af_softReset) begin
      state_q     <= ST_IDLE;
      lock_cnt_q  <= '0;
      num_words_q <= '0;
      tx_sent_q   <= '0;
      tx_seq_q    <= '0;
      rx_seq_q    <= '0;
      rx_words_q  <= '0;
      err_count_q <= '0;
      idle_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      valid_q     <= 1'b0;
      partial_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      num_words_q <= num_words_d;
      tx_sent_q   <= tx_sent_d;
      tx_seq_q    <= tx_seq_d;
      rx_seq_q    <= rx_seq_d;
      rx_words_q  <= rx_words_d;
      err_count_q <= err_count_d;
      idle_cnt_q  <= idle_cnt_d;
      timeout_q   <= timeout_d;
      valid_q     <= valid_d;
      partial_q   <= partial_d;
    end
  end

  assign busy      = checking;
  assign done      = (state_q == ST_DONE);
  assign pass      = done && (err_count_q == 16'd0) && !timeout_q && (rx_words_q == num_words_q);
  assign err_count = err_count_q;
  assign rx_words  = rx_words_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_hssi_lpbk_tester.sv
// Self-checking bench for hssi_lpbk_tester: table-driven loopback scenarios,
// hand-written timing/reset sequences and randomized trials against a model.
module tb_hssi_lpbk_tester;

  localparam int NL   = 4;
  localparam int DW   = 64;
  localparam int TO   = 200;
  localparam int MAXW = 128;
  localparam int VB   = 17;

  logic              pClk;
  logic              rst;
  logic              start;
  logic [31:0]       num_words;
  logic              rx_ready;
  logic [NL*DW-1:0]  tx_data;
  logic [NL*18-1:0]  tx_control;
  logic [NL*DW-1:0]  rx_data;
  logic [NL*20-1:0]  rx_control;
  logic              busy, done, pass, timeout;
  logic [15:0]       err_count;
  logic [31:0]       rx_words;

  hssi_lpbk_tester #(.NUM_LANES(NL), .LANE_DW(DW), .TIMEOUT_CYC(TO)) dut (
    .pClk(pClk), .pck_cp2af_softReset(rst), .start(start), .num_words(num_words),
    .rx_ready(rx_ready), .tx_data(tx_data), .tx_control(tx_control),
    .rx_data(rx_data), .rx_control(rx_control), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .rx_words(rx_words), .timeout(timeout)
  );

  initial pClk = 1'b0;
  always #5 pClk = ~pClk;

  // Loopback channel with per-word fault injection indexed by tx word number.
  int               rx_mode;   // 0 loopback, 1 silent, 2 all-valid garbage
  logic [NL*DW-1:0] flip_tab [MAXW];
  logic [NL-1:0]    drop_tab [MAXW];
  int               widx;

  always @(posedge pClk) begin
    if (rst || (start && !busy)) widx <= 0;
    else if (tx_control[VB])     widx <= widx + 1;
  end

  always_comb begin
    rx_data    = '0;
    rx_control = '0;
    if (rx_mode == 0) begin
      rx_data = tx_data;
      for (int p = 0; p < NL; p++) rx_control[p*20 +: 20] = {2'b00, tx_control[p*18 +: 18]};
      if (tx_control[VB] && widx < MAXW) begin
        rx_data = tx_data ^ flip_tab[widx];
        for (int p = 0; p < NL; p++)
          if (drop_tab[widx][p]) rx_control[p*20 + VB] = 1'b0;
      end
    end else if (rx_mode == 2) begin
      for (int p = 0; p < NL; p++) begin
        rx_data[p*DW +: DW]   = 64'hDEAD_BEEF_0BAD_F00D;
        rx_control[p*20 + VB] = 1'b1;
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_tabs();
    for (int i = 0; i < MAXW; i++) begin
      flip_tab[i] = '0;
      drop_tab[i] = '0;
    end
  endtask

  task automatic start_test(input logic [31:0] n);
    @(posedge pClk); #1;
    num_words = n;
    start     = 1'b1;
    @(posedge pClk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    bit ok;
    ok  = 1'b0;
    cyc = 0;
    while (cyc < budget && !ok) begin
      @(negedge pClk);
      cyc++;
      if (done) ok = 1'b1;
    end
    chk("done_reached", 64'(ok), 64'd1);
  endtask

  // Reference model: walk the sent words in order, decide validity and
  // compare each received lane with {lane, expected sequence}.
  task automatic model(input int n, output int e_words, output int e_err, output bit e_to);
    logic [DW-1:0] txv, rxv, expv;
    int rseq;
    rseq = 0; e_words = 0; e_err = 0;
    for (int i = 0; i < n; i++) begin
      if (drop_tab[i] != '0) begin
        e_err += NL;
      end else begin
        for (int p = 0; p < NL; p++) begin
          txv  = {8'(p), 56'(i)};
          rxv  = txv ^ flip_tab[i][p*DW +: DW];
          expv = {8'(p), 56'(rseq)};
          if (rxv != expv) e_err++;
        end
        rseq++;
        e_words++;
      end
    end
    e_to = (e_words != n);
  endtask

  typedef struct {
    int unsigned n;
    int          mode;
    int          fword;
    logic [3:0]  flanes;
    int          fbit;
    int          dword;
    logic [3:0]  dlanes;
    int unsigned e_words;
    int unsigned e_err;
    bit          e_pass;
    bit          e_to;
  } vec_t;

  vec_t vecs [8];
  int   lat [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, n, e_w, e_e;
    bit e_t, early;
    logic [63:0] first_w0, first_w3;
    logic [31:0] hold_words;
    logic [15:0] hold_err;

    rst = 1'b1; start = 1'b0; num_words = '0; rx_ready = 1'b1; rx_mode = 0;
    clear_tabs();
    repeat (3) @(posedge pClk);
    #1;
    // Reset state
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_pass", 64'(pass), 0);
    chk("rst_timeout", 64'(timeout), 0);
    chk("rst_err", 64'(err_count), 0);
    chk("rst_words", 64'(rx_words), 0);
    chk("rst_txctl", 64'(tx_control), 0);
    chk("rst_txdata", tx_data[63:0], 0);
    rst = 1'b0;

    vecs[0] = '{100, 0, 0, 4'b0000, 0,  0, 4'b0000, 100, 0,  1'b1, 1'b0};
    vecs[1] = '{100, 0, 9, 4'b0100, 0,  0, 4'b0000, 100, 1,  1'b0, 1'b0};
    vecs[2] = '{0,   0, 0, 4'b0000, 0,  0, 4'b0000, 0,   0,  1'b1, 1'b0};
    vecs[3] = '{1,   0, 0, 4'b0000, 0,  0, 4'b0000, 1,   0,  1'b1, 1'b0};
    vecs[4] = '{5,   0, 4, 4'b1001, 63, 0, 4'b0000, 5,   2,  1'b0, 1'b0};
    vecs[5] = '{20,  1, 0, 4'b0000, 0,  0, 4'b0000, 0,   0,  1'b0, 1'b1};
    vecs[6] = '{10,  0, 0, 4'b0000, 0,  3, 4'b0010, 9,   28, 1'b0, 1'b1};
    vecs[7] = '{3,   0, 0, 4'b1111, 30, 0, 4'b0000, 3,   4,  1'b0, 1'b0};

    foreach (vecs[v]) begin
      clear_tabs();
      for (int p = 0; p < NL; p++)
        if (vecs[v].flanes[p]) flip_tab[vecs[v].fword][p*DW + vecs[v].fbit] = 1'b1;
      drop_tab[vecs[v].dword] = vecs[v].dlanes;
      rx_mode = vecs[v].mode;
      start_test(vecs[v].n);
      wait_done(int'(vecs[v].n) + TO + 60, lat[v]);
      chk($sformatf("v%0d_words", v), 64'(rx_words), 64'(vecs[v].e_words));
      chk($sformatf("v%0d_err", v), 64'(err_count), 64'(vecs[v].e_err));
      chk($sformatf("v%0d_pass", v), 64'(pass), 64'(vecs[v].e_pass));
      chk($sformatf("v%0d_timeout", v), 64'(timeout), 64'(vecs[v].e_to));
    end
    chk("lat_100_words", 64'(lat[0] >= 105 && lat[0] <= 115), 1);
    chk("lat_zero_words", 64'(lat[2] <= 12), 1);
    rx_mode = 0;
    clear_tabs();

    // Valid rx traffic while DONE must not move the counters.
    hold_words = rx_words;
    hold_err   = err_count;
    rx_mode = 2;
    repeat (10) @(posedge pClk);
    #1;
    chk("done_hold_words", 64'(rx_words), 64'(hold_words));
    chk("done_hold_err", 64'(err_count), 64'(hold_err));
    chk("done_hold_state", 64'(done), 1);
    rx_mode = 0;

    // Timeout exactly TO cycles after RUN is entered.
    rx_mode = 1;
    start_test(20);
    n = 0;
    while (!tx_control[VB] && n < 50) begin @(negedge pClk); n++; end
    chk("to_run_seen", 64'(tx_control[VB]), 1);
    n = 0;
    while (!timeout && n < TO + 20) begin @(negedge pClk); n++; end
    chk("to_latency", 64'(n), 64'(TO));
    chk("to_done", 64'(done), 1);
    chk("to_pass", 64'(pass), 0);
    rx_mode = 0;

    // Lock qualification with a toggling rx_ready.
    rx_ready = 1'b0;
    early = 1'b0;
    start_test(5);
    for (int k = 0; k < 20; k++) begin
      rx_ready = (k % 2 == 0);
      @(negedge pClk);
      if (tx_control[VB]) early = 1'b1;
      @(posedge pClk); #1;
    end
    chk("lock_busy", 64'(busy), 1);
    chk("lock_no_early_tx", 64'(early), 0);
    rx_ready = 1'b1;
    n = 0;
    while (n < 30) begin
      @(negedge pClk);
      if (tx_control[VB]) break;
      n++;
    end
    chk("lock_latency", 64'(n), 8);
    wait_done(100, cyc);
    chk("lock_pass", 64'(pass), 1);

    // Reset at word 50 of 100, then a clean rerun.
    start_test(100);
    n = 0;
    while (widx < 50 && n < 200) begin @(negedge pClk); n++; end
    chk("mid_reached_50", 64'(widx >= 50), 1);
    rst = 1'b1;
    @(posedge pClk); #1;
    chk("mid_rst_txctl", 64'(tx_control), 0);
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_words", 64'(rx_words), 0);
    rst = 1'b0;
    start_test(100);
    n = 0;
    while (!tx_control[VB] && n < 50) begin @(negedge pClk); n++; end
    first_w0 = tx_data[0 +: 64];
    first_w3 = tx_data[3*DW +: 64];
    chk("rerun_lane0_seq0", first_w0, 64'h0);
    chk("rerun_lane3_seq0", first_w3, 64'h0300_0000_0000_0000);
    wait_done(200, cyc);
    chk("rerun_words", 64'(rx_words), 100);
    chk("rerun_pass", 64'(pass), 1);

    // Randomized trials against the model.
    for (int t = 0; t < 8; t++) begin
      clear_tabs();
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 4) == 0)
          flip_tab[i][$urandom_range(0, NL*DW-1)] = 1'b1;
        if (t >= 6 && $urandom_range(0, 14) == 0)
          drop_tab[i][$urandom_range(0, NL-1)] = 1'b1;
      end
      model(n, e_w, e_e, e_t);
      start_test(n);
      wait_done(n + TO + 60, cyc);
      chk($sformatf("rnd%0d_words", t), 64'(rx_words), 64'(e_w));
      chk($sformatf("rnd%0d_err", t), 64'(err_count), 64'(e_e));
      chk($sformatf("rnd%0d_timeout", t), 64'(timeout), 64'(e_t));
      chk($sformatf("rnd%0d_pass", t), 64'(pass), 64'(!e_t && e_e == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
